keyboard_code_fifo: RTL and testbench
=====================================

# keyboard_code_fifo

Consumer stage behind the keypad front end (scan, filter, latch register). It watches the 16-bit latched key bitmap and snapshots it when any bit is set. It then acknowledges the front end with a one-cycle `key_clear` and converts the snapshot into 4-bit key codes queued in a small FIFO. The Cortex-M0 peripheral wrapper pops the codes and uses `irq` as its keypad interrupt source.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2
- `clk`  in  1  single system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `key_data`  in  16  latched key bitmap from front end; bit i = key i pressed since last clear
- `key_clear`  out  1  one-cycle pulse, clears front-end latch register
- `rd_en`  in  1  pop request from bus side
- `rd_data`  out  4  head-of-FIFO key code (first-word fall-through)
- `fifo_empty`  out  1  no codes queued
- `fifo_full`  out  1  DEPTH codes queued
- `count`  out  $clog2(DEPTH)+1  codes queued
- `overflow`  out  1  sticky: a code was dropped
- `ovf_clear`  in  1  clears `overflow`
- `irq`  out  1  level interrupt = !fifo_empty

## Operation
- FSM states are IDLE, CLEAR and DRAIN; 16-bit snapshot register `snap`.
- IDLE
  - `key_data` == 0: stay.
  - `key_data` != 0: `snap` ← `key_data`, `key_clear` ← 1, go to CLEAR.
- CLEAR: `key_clear` ← 0, go to DRAIN. The front end clears on the edge ending CLEAR.
- DRAIN
  - Each cycle, take the lowest set bit index i of `snap`, push code i, and clear bit i in `snap`.
  - When the bit being cleared is the last one set, go to IDLE. DRAIN therefore lasts popcount(`snap`) cycles.
- Presses arriving after the clear accumulate upstream and are picked up on the next IDLE visit.
- Push when full and no pop in the same cycle: the code is dropped, `overflow` ← 1, and the FSM still advances.
- Pop (`rd_en` & !`fifo_empty`): head advances. `rd_en` while empty is ignored.
- Simultaneous push and pop:
  - Always legal, including when full: count unchanged, no overflow.
  - When empty, the pop is ignored and the push lands.
- `overflow` clear: `ovf_clear` clears it. If set and clear occur in the same cycle, set wins.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- `count` is registered, range 0..DEPTH. `fifo_empty`, `fifo_full` and `irq` are derived from `count`.

## Timing
- Reset values:
  - state IDLE, `snap` 0, `key_clear` 0
  - pointers 0, `count` 0, `fifo_empty` 1, `fifo_full` 0, `irq` 0, `overflow` 0
  - `rd_data` = mem[0], don't-care while empty
- Reset mid-operation: FSM returns to IDLE, the snapshot is discarded, the FIFO is emptied, and no `key_clear` is issued.
- Relative to sampling edge E0 (IDLE sees non-zero `key_data`):
  - `key_clear` is high between E0 and E1.
  - The first code is written at E2; `rd_data`, `count`=1 and `irq` are valid after E2.
  - The k-th code is written at E(k+1).
- Earliest re-sample in IDLE is one edge after the last DRAIN push.
- `rd_data` is valid combinationally from the head pointer in the same cycle `fifo_empty` is 0. The pop takes effect at the edge where `rd_en` is high.
- `key_clear` is never high for two consecutive cycles.

## Structure
- `keyboard_pkg`:
  - `KEY_W`=16, `CODE_W`=4
  - FSM state enum (IDLE, CLEAR, DRAIN)
  - lowest-set-bit encode function
- Sub-module `key_code_fifo`: generic synchronous FWFT FIFO (`DEPTH`, `CODE_W`) providing `count`, full/empty and overflow logic. The top holds the FSM, snapshot register and encoder.

## Test plan
- Single key: `key_data`=0x0020 → `key_clear` pulses for 1 cycle, code 5 is readable after E2, `irq`=1; pop → `fifo_empty`=1, `irq`=0.
- Multiple keys: `key_data`=0x8101 → one `key_clear`, codes pushed in order 0, 8, 15 on E2..E4, `count`=3.
- Overflow: DEPTH=8, no pops, `key_data`=0x03FF → 8 codes (0..7) kept, codes 8 and 9 dropped, `overflow`=1, `fifo_full`=1. `ovf_clear` with a concurrent drop → `overflow` stays 1.
- Full with concurrent pop: FIFO full, `rd_en`=1 during a DRAIN push → push accepted, `count` stays 8, `overflow` stays 0.
- Pop while empty plus key arriving mid-DRAIN: `rd_en`=1 while empty → no change. `key_data` goes 0x0004 during DRAIN → captured on the next IDLE, second `key_clear` issued, code 2 queued.
- Reset in CLEAR/DRAIN: assert `rst` for 1 cycle → all outputs at reset values the next cycle, no further pushes or `key_clear`.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared widths, FSM state type and the lowest-set-bit encoder for the keypad
// code FIFO stage.
package keyboard_pkg;

    localparam int unsigned KEY_W  = 16;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDrain
    } kbd_state_e;

    // Descending scan so the lowest set index is the final assignment.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [KEY_W-1:0] bits);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (bits[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_code_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered occupancy
// count and a sticky overflow flag.
module key_code_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    input  logic                       ovf_clear_i,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop, drop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign rdata_o    = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a push into a full FIFO is
    // accepted whenever a real pop accompanies it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop    = push_i && !do_push;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clear_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/keyboard_code_fifo.sv
// Snapshots the latched key bitmap, acknowledges the front end, and drains the
// snapshot lowest-key-first into a code FIFO read by the bus wrapper.
module keyboard_code_fifo
    import keyboard_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KEY_W-1:0]         key_data,
    output logic                     key_clear,
    input  logic                     rd_en,
    output logic [CODE_W-1:0]        rd_data,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clear,
    output logic                     irq
);

    kbd_state_e         state_q, state_d;
    logic [KEY_W-1:0]   snap_q, snap_d;
    logic               key_clear_q, key_clear_d;
    logic               push;
    logic [CODE_W-1:0]  push_code;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        key_clear_d = 1'b0;
        push        = 1'b0;
        push_code   = lowest_set(snap_q);
        unique case (state_q)
            StIdle: begin
                if (key_data != '0) begin
                    snap_d      = key_data;
                    key_clear_d = 1'b1;
                    state_d     = StClear;
                end
            end
            StClear: state_d = StDrain;
            StDrain: begin
                push   = 1'b1;
                // Clears the lowest set bit, matching the code just pushed.
                snap_d = snap_q & (snap_q - KEY_W'(1));
                if (snap_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            snap_q      <= '0;
            key_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            key_clear_q <= key_clear_d;
        end
    end

    assign key_clear = key_clear_q;
    assign irq       = !fifo_empty;

    key_code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .wdata_i     (push_code),
        .pop_i       (rd_en),
        .rdata_o     (rd_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (count),
        .ovf_clear_i (ovf_clear),
        .overflow_o  (overflow)
    );

endmodule

// File: tb/tb_keyboard_code_fifo.sv
// Directed bench for keyboard_code_fifo: drives key bitmaps and pops, checking
// against hand-computed codes, counts and flags.
module tb_keyboard_code_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_data;
    logic        key_clear;
    logic        rd_en;
    logic [3:0]  rd_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [3:0]  count;
    logic        overflow;
    logic        ovf_clear;
    logic        irq;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    keyboard_code_fifo #(
        .DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_data   (key_data),
        .key_clear  (key_clear),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .count      (count),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_regs(input string tag);
        check_eq({tag, ".key_clear"}, key_clear, 0);
        check_eq({tag, ".count"}, count, 0);
        check_eq({tag, ".empty"}, fifo_empty, 1);
        check_eq({tag, ".full"}, fifo_full, 0);
        check_eq({tag, ".irq"}, irq, 0);
        check_eq({tag, ".overflow"}, overflow, 0);
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] code);
        check_eq(tag, rd_data, code);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    logic [3:0] wrap_codes [8];

    initial begin
        rst       = 1'b1;
        key_data  = '0;
        rd_en     = 1'b0;
        ovf_clear = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check_idle_regs("reset");

        // Single key 5.
        key_data = 16'h0020;
        step();                                  // E0
        check_eq("single.clr_E0", key_clear, 1);
        step();                                  // E1
        key_data = '0;
        check_eq("single.clr_E1", key_clear, 0);
        check_eq("single.cnt_E1", count, 0);
        step();                                  // E2
        check_eq("single.cnt_E2", count, 1);
        check_eq("single.irq_E2", irq, 1);
        check_eq("single.code", rd_data, 5);
        step();
        check_eq("single.clr_once", key_clear, 0);
        pop_expect("single.pop", 5);
        check_eq("single.empty", fifo_empty, 1);
        check_eq("single.irq_off", irq, 0);

        // Keys 0, 8, 15 in one snapshot.
        key_data = 16'h8101;
        step();
        check_eq("multi.clr_E0", key_clear, 1);
        step();
        key_data = '0;
        check_eq("multi.clr_E1", key_clear, 0);
        step();
        check_eq("multi.cnt_E2", count, 1);
        check_eq("multi.head_E2", rd_data, 0);
        step();
        check_eq("multi.cnt_E3", count, 2);
        step();
        check_eq("multi.cnt_E4", count, 3);
        step();
        check_eq("multi.cnt_hold", count, 3);
        check_eq("multi.clr_none", key_clear, 0);
        pop_expect("multi.pop0", 0);
        pop_expect("multi.pop8", 8);
        pop_expect("multi.pop15", 15);
        check_eq("multi.empty", fifo_empty, 1);

        // Ten keys into eight slots, no pops.
        key_data = 16'h03FF;
        step();
        step();
        key_data = '0;
        for (int k = 1; k <= 8; k++) step();     // E2..E9
        check_eq("ovf.cnt_full", count, 8);
        check_eq("ovf.full", fifo_full, 1);
        check_eq("ovf.pre", overflow, 0);
        step();                                  // E10: code 8 dropped
        check_eq("ovf.set", overflow, 1);
        ovf_clear = 1'b1;
        step();                                  // E11: code 9 dropped with clear
        ovf_clear = 1'b0;
        check_eq("ovf.set_wins", overflow, 1);
        check_eq("ovf.cnt_after", count, 8);
        check_eq("ovf.head", rd_data, 0);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check_eq("ovf.cleared", overflow, 0);

        // Full FIFO, key 1 pushed while popping in the same cycle.
        key_data = 16'h0002;
        step();
        step();
        key_data = '0;
        rd_en = 1'b1;
        step();                                  // E2: push + pop
        rd_en = 1'b0;
        check_eq("fullpop.cnt", count, 8);
        check_eq("fullpop.ovf", overflow, 0);
        check_eq("fullpop.full", fifo_full, 1);
        wrap_codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1};
        for (int k = 0; k < 8; k++) pop_expect($sformatf("fullpop.drain%0d", k), wrap_codes[k]);
        check_eq("fullpop.empty", fifo_empty, 1);

        // Pop while empty is ignored.
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_eq("emptypop.cnt", count, 0);
        check_eq("emptypop.empty", fifo_empty, 1);

        // Keys 0,1; first push coincides with a pop on empty; key 2 arrives mid-DRAIN.
        key_data = 16'h0003;
        step();                                  // E0
        step();                                  // E1
        key_data = '0;
        rd_en = 1'b1;
        step();                                  // E2: push lands, pop ignored
        rd_en = 1'b0;
        check_eq("late.cnt_E2", count, 1);
        key_data = 16'h0004;
        step();                                  // E3: last push, back to IDLE
        check_eq("late.cnt_E3", count, 2);
        check_eq("late.clr_E3", key_clear, 0);
        step();                                  // E4: IDLE sees key 2
        check_eq("late.clr_E4", key_clear, 1);
        step();
        key_data = '0;
        check_eq("late.clr_E5", key_clear, 0);
        step();
        check_eq("late.cnt_E6", count, 3);
        pop_expect("late.pop0", 0);
        pop_expect("late.pop1", 1);
        pop_expect("late.pop2", 2);

        // Reset during DRAIN.
        key_data = 16'h00F0;
        step();
        step();
        key_data = '0;
        step();
        check_eq("rstdrain.cnt", count, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_regs("rstdrain");
        for (int k = 0; k < 4; k++) step();
        check_idle_regs("rstdrain.after");

        // Reset during CLEAR.
        key_data = 16'h0001;
        step();
        key_data = '0;
        check_eq("rstclr.clr_E0", key_clear, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_regs("rstclr");
        for (int k = 0; k < 3; k++) step();
        check_idle_regs("rstclr.after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // key_clear must never be high on two consecutive sampled cycles.
    logic prev_clr = 1'b0;
    always @(negedge clk) begin
        if (prev_clr && key_clear) begin
            n_miss++;
            $display("FAIL key_clear_double: got 1, expected 0 (t=%0t)", $time);
        end
        prev_clr <= key_clear;
    end

endmodule
